// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter_if
// Purpose  : Bundle of the write arbiter signals: two writeback request ports,
//            the register file write port, two forwarding lookups and the
//            queue occupancy.
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_write_arbiter_if #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  aValid;
  logic                  aReady;
  logic [4:0]            aAddr;
  logic [WORD_WIDTH-1:0] aData;
  logic                  bValid;
  logic                  bReady;
  logic [4:0]            bAddr;
  logic [WORD_WIDTH-1:0] bData;
  logic [4:0]            regWriteAddr;
  logic [WORD_WIDTH-1:0] dataToWrite;
  logic                  toWrite;
  logic [4:0]            lookAddr1;
  logic [4:0]            lookAddr2;
  logic                  hit1;
  logic                  hit2;
  logic [WORD_WIDTH-1:0] fwdData1;
  logic [WORD_WIDTH-1:0] fwdData2;
  logic [CNT_W-1:0]      count;

  // Requesters and register file side
  modport master (
    output aValid, aAddr, aData, bValid, bAddr, bData, lookAddr1, lookAddr2,
    input  aReady, bReady, regWriteAddr, dataToWrite, toWrite,
           hit1, hit2, fwdData1, fwdData2, count
  );

  // Arbiter side
  modport slave (
    input  aValid, aAddr, aData, bValid, bAddr, bData, lookAddr1, lookAddr2,
    output aReady, bReady, regWriteAddr, dataToWrite, toWrite,
           hit1, hit2, fwdData1, fwdData2, count
  );
endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_write_arbiter
// Purpose  : Merges pipeline (A) and long-latency (B) writebacks into an
//            in-order queue, drains one entry per cycle into the register
//            file write port and forwards the youngest pending value.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  regfile_write_arbiter_if.slave bus
);
  localparam int               PTR_W   = $clog2(DEPTH);
  localparam int               CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [4:0]            r_addr [DEPTH];
  logic [WORD_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [4:0]            r_out_addr;
  logic [WORD_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;

  logic [CNT_W-1:0]      w_free;
  logic                  w_a_fire;
  logic                  w_b_fire;
  logic                  w_a_push;
  logic                  w_b_push;
  logic                  w_pop;
  logic [PTR_W-1:0]      w_b_slot;
  logic [CNT_W-1:0]      w_push_cnt;
  logic [PTR_W-1:0]      w_slot [DEPTH];
  logic                  w_live [DEPTH];
  logic                  w_hit1;
  logic                  w_hit2;
  logic [WORD_WIDTH-1:0] w_fwd1;
  logic [WORD_WIDTH-1:0] w_fwd2;

  // Readies only look at the current occupancy; a same-edge pop is not credited.
  assign w_free     = DEPTH_C - r_count;
  assign bus.aReady = (w_free != '0);
  assign bus.bReady = (w_free >= CNT_W'(2)) | ((w_free == CNT_W'(1)) & ~bus.aValid);

  // Address 0 completes the handshake but is dropped instead of enqueued.
  assign w_a_fire   = bus.aValid & bus.aReady;
  assign w_b_fire   = bus.bValid & bus.bReady;
  assign w_a_push   = w_a_fire & (bus.aAddr != 5'd0);
  assign w_b_push   = w_b_fire & (bus.bAddr != 5'd0);
  assign w_pop      = (r_count != '0);
  assign w_b_slot   = r_wr_ptr + PTR_W'(w_a_push);
  assign w_push_cnt = CNT_W'(w_a_push) + CNT_W'(w_b_push);

  // Age-ordered view of the queue: slot 0 is the head (oldest).
  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_age
      assign w_slot[g] = r_rd_ptr + PTR_W'(g);
      assign w_live[g] = (CNT_W'(g) < r_count);
    end
  endgenerate

  // Queue storage; A lands before B when both push on the same edge.
  always_ff @(posedge clk) begin
    if (w_a_push) begin
      r_addr[r_wr_ptr] <= bus.aAddr;
      r_data[r_wr_ptr] <= bus.aData;
    end
    if (w_b_push) begin
      r_addr[w_b_slot] <= bus.bAddr;
      r_data[w_b_slot] <= bus.bData;
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_a_push) + PTR_W'(w_b_push);
      r_count  <= r_count + w_push_cnt - CNT_W'(w_pop);
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
        r_out_addr  <= r_addr[r_rd_ptr];
        r_out_data  <= r_data[r_rd_ptr];
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Forwarding: start from the output stage, later (younger) queue slots override.
  always_comb begin
    w_hit1 = 1'b0;
    w_fwd1 = '0;
    w_hit2 = 1'b0;
    w_fwd2 = '0;
    if (r_out_valid && (r_out_addr == bus.lookAddr1)) begin
      w_hit1 = 1'b1;
      w_fwd1 = r_out_data;
    end
    if (r_out_valid && (r_out_addr == bus.lookAddr2)) begin
      w_hit2 = 1'b1;
      w_fwd2 = r_out_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (w_live[i] && (r_addr[w_slot[i]] == bus.lookAddr1)) begin
        w_hit1 = 1'b1;
        w_fwd1 = r_data[w_slot[i]];
      end
      if (w_live[i] && (r_addr[w_slot[i]] == bus.lookAddr2)) begin
        w_hit2 = 1'b1;
        w_fwd2 = r_data[w_slot[i]];
      end
    end
    if (bus.lookAddr1 == 5'd0) begin
      w_hit1 = 1'b0;
      w_fwd1 = '0;
    end
    if (bus.lookAddr2 == 5'd0) begin
      w_hit2 = 1'b0;
      w_fwd2 = '0;
    end
  end

  assign bus.hit1         = w_hit1;
  assign bus.hit2         = w_hit2;
  assign bus.fwdData1     = w_fwd1;
  assign bus.fwdData2     = w_fwd2;
  assign bus.regWriteAddr = r_out_addr;
  assign bus.dataToWrite  = r_out_data;
  assign bus.toWrite      = r_out_valid;
  assign bus.count        = r_count;
endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_write_arbiter
// Purpose  : Directed and randomized bench for regfile_write_arbiter with a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;
  localparam int WW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]    addr;
    logic [WW-1:0] data;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(.WORD_WIDTH(WW), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: pending queue plus output stage
  ent_t          q[$];
  logic          m_tw   = 1'b0;
  logic [4:0]    m_addr = '0;
  logic [WW-1:0] m_data = '0;
  logic          a_acc  = 1'b0;
  logic          b_acc  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to la, searching tail -> head -> output stage
  task automatic lookup(input logic [4:0] la, output logic h, output logic [WW-1:0] d);
    h = 1'b0;
    d = '0;
    if (la != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!h && q[i].addr == la) begin
          h = 1'b1;
          d = q[i].data;
        end
      end
      if (!h && m_tw && m_addr == la) begin
        h = 1'b1;
        d = m_data;
      end
    end
  endtask

  task automatic check_all();
    logic          h;
    logic [WW-1:0] d;
    int            fr;
    fr = DEPTH - q.size();
    chk("aReady", 64'(bus.aReady), 64'(fr >= 1));
    chk("bReady", 64'(bus.bReady), 64'((fr >= 2) || (fr == 1 && !bus.aValid)));
    chk("toWrite", 64'(bus.toWrite), 64'(m_tw));
    chk("regWriteAddr", 64'(bus.regWriteAddr), 64'(m_addr));
    chk("dataToWrite", 64'(bus.dataToWrite), 64'(m_data));
    chk("count", 64'(bus.count), 64'(q.size()));
    lookup(bus.lookAddr1, h, d);
    chk("hit1", 64'(bus.hit1), 64'(h));
    chk("fwdData1", 64'(bus.fwdData1), 64'(d));
    lookup(bus.lookAddr2, h, d);
    chk("hit2", 64'(bus.hit2), 64'(h));
    chk("fwdData2", 64'(bus.fwdData2), 64'(d));
  endtask

  // Advance the model by one clock edge using the inputs currently driven
  task automatic model_edge();
    int   fr;
    ent_t e;
    fr    = DEPTH - q.size();
    a_acc = bus.aValid && (fr >= 1);
    b_acc = bus.bValid && ((fr >= 2) || (fr == 1 && !bus.aValid));
    if (q.size() > 0) begin
      e      = q.pop_front();
      m_tw   = 1'b1;
      m_addr = e.addr;
      m_data = e.data;
    end else begin
      m_tw = 1'b0;
    end
    if (a_acc && bus.aAddr != 5'd0) begin
      e.addr = bus.aAddr;
      e.data = bus.aData;
      q.push_back(e);
    end
    if (b_acc && bus.bAddr != 5'd0) begin
      e.addr = bus.bAddr;
      e.data = bus.bData;
      q.push_back(e);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_tw   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One cycle: drive at negedge, check, then step the model at posedge
  task automatic step(input logic av, input logic [4:0] aa, input logic [WW-1:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [WW-1:0] bd,
                      input logic [4:0] l1, input logic [4:0] l2);
    @(negedge clk);
    bus.aValid    = av;
    bus.aAddr     = aa;
    bus.aData     = ad;
    bus.bValid    = bv;
    bus.bAddr     = ba;
    bus.bData     = bd;
    bus.lookAddr1 = l1;
    bus.lookAddr2 = l2;
    #1;
    check_all();
    @(posedge clk);
    model_edge();
  endtask

  logic          pav, pbv;
  logic [4:0]    paa, pba;
  logic [WW-1:0] pad, pbd;
  int            nxt;

  initial begin
    bus.aValid = 1'b0; bus.aAddr = '0; bus.aData = '0;
    bus.bValid = 1'b0; bus.bAddr = '0; bus.bData = '0;
    bus.lookAddr1 = 5'd8; bus.lookAddr2 = 5'd0;
    model_reset();
    pav = 1'b0; pbv = 1'b0; paa = '0; pba = '0; pad = '0; pbd = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_toWrite", 64'(bus.toWrite), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_hit1", 64'(bus.hit1), 64'd0);
    chk("rst_dataToWrite", 64'(bus.dataToWrite), 64'd0);
    rst_n = 1'b1;

    // Single A write to r8: queued, then output stage, then gone
    step(1, 5'd8, 32'h11, 0, 5'd0, 32'h0, 5'd8, 5'd0);
    #1;
    chk("t1_count1", 64'(bus.count), 64'd1);
    chk("t1_hit_q", 64'(bus.hit1), 64'd1);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd8, 5'd0);
    #1;
    chk("t1_toWrite", 64'(bus.toWrite), 64'd1);
    chk("t1_addr", 64'(bus.regWriteAddr), 64'd8);
    chk("t1_data", 64'(bus.dataToWrite), 64'h11);
    chk("t1_hit_out", 64'(bus.hit1), 64'd1);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd8, 5'd0);
    #1;
    chk("t1_hit_gone", 64'(bus.hit1), 64'd0);

    // Same address on A and B: B is younger and wins forwarding
    step(1, 5'd9, 32'h1, 1, 5'd9, 32'h2, 5'd9, 5'd8);
    #1;
    chk("t2_fwd_both", 64'(bus.fwdData1), 64'h2);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd0);
    #1;
    chk("t2_commit1", 64'(bus.dataToWrite), 64'h1);
    chk("t2_fwd_one", 64'(bus.fwdData1), 64'h2);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd0);
    #1;
    chk("t2_commit2", 64'(bus.dataToWrite), 64'h2);
    repeat (2) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd9, 5'd0);

    // Address 0 on both ports: accepted, never queued
    step(1, 5'd0, 32'hFFFF, 1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    #1;
    chk("t4_count", 64'(bus.count), 64'd0);
    chk("t4_toWrite", 64'(bus.toWrite), 64'd0);
    chk("t4_hit0", 64'(bus.hit1), 64'd0);
    step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd0, 5'd0);

    // Saturation: A and B valid every cycle with distinct addresses
    nxt = 1;
    for (int k = 0; k < 24; k++) begin
      if (!pav) begin pav = 1; paa = 5'(nxt); pad = $urandom; nxt = (nxt % 31) + 1; end
      if (!pbv) begin pbv = 1; pba = 5'(nxt); pbd = $urandom; nxt = (nxt % 31) + 1; end
      step(pav, paa, pad, pbv, pba, pbd, paa, pba);
      if (a_acc) pav = 0;
      if (b_acc) pbv = 0;
    end
    pav = 0; pbv = 0;
    repeat (6) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd1, 5'd2);

    // Build three queued entries, then reset asynchronously mid-cycle
    step(1, 5'd3, 32'h33, 1, 5'd4, 32'h44, 5'd3, 5'd4);
    step(1, 5'd5, 32'h55, 1, 5'd6, 32'h66, 5'd5, 5'd6);
    #1;
    chk("t5_count3", 64'(bus.count), 64'd3);
    @(negedge clk);
    bus.aValid = 0;
    bus.bValid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_toWrite", 64'(bus.toWrite), 64'd0);
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_hit1", 64'(bus.hit1), 64'd0);
    chk("t5_hit2", 64'(bus.hit2), 64'd0);
    chk("t5_fwd1", 64'(bus.fwdData1), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd5, 5'd6);

    // Randomized traffic with held requests; pointers wrap many times
    for (int k = 0; k < 400; k++) begin
      if (!pav) begin
        pav = ($urandom % 4) != 0;
        paa = 5'($urandom_range(0, 7));
        pad = $urandom;
      end
      if (!pbv) begin
        pbv = ($urandom % 3) != 0;
        pba = 5'($urandom_range(0, 7));
        pbd = $urandom;
      end
      step(pav, paa, pad, pbv, pba, pbd, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (a_acc) pav = 0;
      if (b_acc) pbv = 0;
    end
    repeat (6) step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 5'd1, 5'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
